// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: parses received byte frames, drives register-file
// writes/reads and ALU operations, and pushes responses into the TX FIFO.
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]   RF_Address,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    FIFO_FULL,
    output logic                    CMD_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

    // Every output is a flop; the next-value logic fills this whole bundle.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rf_address;
        logic                  rf_wr_en;
        logic                  rf_rd_en;
        logic [DATA_WIDTH-1:0] rf_wr_data;
        logic                  alu_en;
        logic [FUN_WIDTH-1:0]  alu_fun;
        logic                  clk_gate_en;
        logic [DATA_WIDTH-1:0] tx_p_data;
        logic                  tx_d_vld;
        logic                  cmd_err;
    } ctrl_t;

    state_t                  state_q, state_d;
    ctrl_t                   ctrl_q, ctrl_d;
    logic [2*DATA_WIDTH-1:0] resp_q, resp_d;
    logic                    resp_two_q, resp_two_d;

    // NOTE: every register here is control or a small datapath latch, so all of
    // them take the async reset and the outputs read 0 the moment RST falls.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            resp_q     <= '0;
            resp_two_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            resp_q     <= resp_d;
            resp_two_q <= resp_two_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_d          = state_q;
        ctrl_d           = ctrl_q;
        ctrl_d.rf_wr_en  = 1'b0;
        ctrl_d.rf_rd_en  = 1'b0;
        ctrl_d.alu_en    = 1'b0;
        ctrl_d.tx_d_vld  = 1'b0;
        ctrl_d.cmd_err   = 1'b0;
        resp_d           = resp_q;
        resp_two_d       = resp_two_q;

        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      state_d = ST_WR_ADDR;
                        CMD_RD:      state_d = ST_RD_ADDR;
                        CMD_ALU_OP:  state_d = ST_ALU_A;
                        CMD_ALU_NOP: state_d = ST_ALU_FUN;
                        default:     ctrl_d.cmd_err = 1'b1;
                    endcase
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    ctrl_d.rf_address = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d           = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    ctrl_d.rf_wr_data = RX_P_DATA;
                    ctrl_d.rf_wr_en   = 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    ctrl_d.rf_address = RX_P_DATA[ADDR_WIDTH-1:0];
                    ctrl_d.rf_rd_en   = 1'b1;
                    state_d           = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                ctrl_d.cmd_err = RX_D_VLD;
                if (RF_RdData_VLD) begin
                    resp_d     = {{DATA_WIDTH{1'b0}}, RF_RdData};
                    resp_two_d = 1'b0;
                    state_d    = ST_TX_LO;
                end
            end
            // Operands land in RF addresses 0 and 1 before the ALU is started.
            ST_ALU_A: begin
                if (RX_D_VLD) begin
                    ctrl_d.rf_address = ADDR_WIDTH'(0);
                    ctrl_d.rf_wr_data = RX_P_DATA;
                    ctrl_d.rf_wr_en   = 1'b1;
                    state_d           = ST_ALU_B;
                end
            end
            ST_ALU_B: begin
                if (RX_D_VLD) begin
                    ctrl_d.rf_address = ADDR_WIDTH'(1);
                    ctrl_d.rf_wr_data = RX_P_DATA;
                    ctrl_d.rf_wr_en   = 1'b1;
                    state_d           = ST_ALU_FUN;
                end
            end
            ST_ALU_FUN: begin
                if (RX_D_VLD) begin
                    ctrl_d.alu_fun = RX_P_DATA[FUN_WIDTH-1:0];
                    ctrl_d.alu_en  = 1'b1;
                    state_d        = ST_ALU_WAIT;
                end
            end
            ST_ALU_WAIT: begin
                ctrl_d.cmd_err = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    resp_d     = ALU_OUT;
                    resp_two_d = 1'b1;
                    state_d    = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                ctrl_d.cmd_err = RX_D_VLD;
                if (!FIFO_FULL) begin
                    ctrl_d.tx_p_data = resp_q[DATA_WIDTH-1:0];
                    ctrl_d.tx_d_vld  = 1'b1;
                    state_d          = resp_two_q ? ST_TX_HI : ST_IDLE;
                end
            end
            ST_TX_HI: begin
                ctrl_d.cmd_err = RX_D_VLD;
                if (!FIFO_FULL) begin
                    ctrl_d.tx_p_data = resp_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    ctrl_d.tx_d_vld  = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Gate follows the registered state so it rises with entry to the FUN state.
        ctrl_d.clk_gate_en = (state_d == ST_ALU_FUN) || (state_d == ST_ALU_WAIT);
    end

    assign RF_Address  = ctrl_q.rf_address;
    assign RF_WrEn     = ctrl_q.rf_wr_en;
    assign RF_RdEn     = ctrl_q.rf_rd_en;
    assign RF_WrData   = ctrl_q.rf_wr_data;
    assign ALU_EN      = ctrl_q.alu_en;
    assign ALU_FUN     = ctrl_q.alu_fun;
    assign CLK_GATE_EN = ctrl_q.clk_gate_en;
    assign TX_P_DATA   = ctrl_q.tx_p_data;
    assign TX_D_VLD    = ctrl_q.tx_d_vld;
    assign CMD_ERR     = ctrl_q.cmd_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: inputs change 1 time unit after the rising edge,
// outputs are read at that point and by a falling-edge pulse monitor.
module tb_uart_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_Address;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;
    logic        CMD_ERR;

    int tests = 0;
    int fails = 0;

    int         wr_cnt, rd_cnt, alu_cnt, err_cnt, full_viol, overlap;
    logic [7:0] tx_q[$];

    uart_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RF_Address    (RF_Address),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_WrData     (RF_WrData),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .FIFO_FULL     (FIFO_FULL),
        .CMD_ERR       (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    // Pulse monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            if (RF_WrEn) wr_cnt++;
            if (RF_RdEn) rd_cnt++;
            if (ALU_EN) alu_cnt++;
            if (CMD_ERR) err_cnt++;
            if (ALU_EN && RF_WrEn) overlap++;
            if (TX_D_VLD) begin
                tx_q.push_back(TX_P_DATA);
                if (FIFO_FULL) full_viol++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One received byte in the current cycle; returns in the cycle its effect shows.
    task automatic put(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; err_cnt = 0; full_viol = 0; overlap = 0;
        tx_q.delete();
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};
    endfunction

    initial begin
        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0; RF_RdData_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        clear_counts();
        tick(); tick();
        check("reset_outputs", all_outs(), 32'h0);
        RST = 1'b1;
        tick();

        // Write frame
        clear_counts();
        put(8'hAA); put(8'h05); put(8'h3C);
        check("wr_en", RF_WrEn, 1);
        check("wr_addr", RF_Address, 5);
        check("wr_data", RF_WrData, 8'h3C);
        tick();
        check("wr_en_one_cycle", RF_WrEn, 0);
        tick();
        check("wr_count", wr_cnt, 1);
        check("wr_no_tx", tx_q.size(), 0);

        // Read frame with a byte injected while waiting for read data
        clear_counts();
        put(8'hBB); put(8'h05);
        check("rd_en", RF_RdEn, 1);
        check("rd_addr", RF_Address, 5);
        tick();
        put(8'h55);
        check("rd_wait_drop_err", CMD_ERR, 1);
        RF_RdData = 8'h3C; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
        check("rd_tx_not_yet", TX_D_VLD, 0);
        tick();
        check("rd_tx_vld", TX_D_VLD, 1);
        check("rd_tx_data", TX_P_DATA, 8'h3C);
        tick();
        check("rd_tx_one_push", TX_D_VLD, 0);
        tick();
        check("rd_push_count", tx_q.size(), 1);
        check("rd_err_count", err_cnt, 1);
        check("rd_strobe_count", rd_cnt, 1);

        // ALU frame with operands
        clear_counts();
        put(8'hCC); put(8'h12);
        check("aluA_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'd0, 8'h12});
        check("aluA_gate", CLK_GATE_EN, 0);
        put(8'h34);
        check("aluB_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'd1, 8'h34});
        check("aluB_gate", CLK_GATE_EN, 1);
        put(8'h00);
        check("alu_en", {ALU_EN, ALU_FUN, RF_WrEn}, {1'b1, 4'd0, 1'b0});
        check("alu_gate_on_en", CLK_GATE_EN, 1);
        tick(); tick();
        check("alu_wait_gate", {CLK_GATE_EN, ALU_EN}, {1'b1, 1'b0});
        ALU_OUT = 16'h0046; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        check("alu_gate_off", CLK_GATE_EN, 0);
        tick();
        check("alu_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h46});
        tick();
        check("alu_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
        tick();
        check("alu_tx_done", TX_D_VLD, 0);
        check("alu_wr_count", wr_cnt, 2);
        check("alu_en_count", alu_cnt, 1);
        check("alu_no_overlap", overlap, 0);

        // ALU frame without operands, response under FIFO backpressure
        clear_counts();
        put(8'hDD);
        check("dd_gate", CLK_GATE_EN, 1);
        put(8'h05);
        check("dd_alu_en", {ALU_EN, ALU_FUN}, {1'b1, 4'd5});
        FIFO_FULL = 1'b1;
        ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_no_push", TX_D_VLD, 0);
            tick();
        end
        check("bp_no_push_last", TX_D_VLD, 0);
        FIFO_FULL = 1'b0;
        tick();
        check("bp_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hEF});
        tick();
        check("bp_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'hBE});
        tick();
        check("bp_tx_done", TX_D_VLD, 0);
        tick();
        check("bp_push_count", tx_q.size(), 2);
        check("bp_order", {tx_q[0], tx_q[1]}, 16'hEFBE);
        check("bp_full_violation", full_viol, 0);
        check("dd_no_rf_write", wr_cnt, 0);

        // Stray valid pulses in IDLE are ignored
        clear_counts();
        RF_RdData_VLD = 1'b1; ALU_OUT_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
        tick(); tick();
        check("stray_vld_no_tx", tx_q.size(), 0);
        check("stray_vld_no_gate", CLK_GATE_EN, 0);

        // Unknown command, then back-to-back frames with no gaps
        clear_counts();
        put(8'h77);
        check("unknown_err", CMD_ERR, 1);
        put(8'hAA);
        check("err_one_cycle", CMD_ERR, 0);
        put(8'h01); put(8'h02);
        check("b2b_wr", {RF_WrEn, RF_Address, RF_WrData}, {1'b1, 4'd1, 8'h02});
        put(8'hBB); put(8'h07);
        check("b2b_rd", {RF_RdEn, RF_Address}, {1'b1, 4'd7});
        tick();
        RF_RdData = 8'h99; RF_RdData_VLD = 1'b1;
        tick();
        RF_RdData_VLD = 1'b0;
        tick();
        check("b2b_rd_tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h99});
        tick();
        check("b2b_err_count", err_cnt, 1);

        // Reset mid-frame
        clear_counts();
        put(8'hAA); put(8'h05);
        check("pre_reset_addr", RF_Address, 5);
        RST = 1'b0;
        #1;
        check("mid_reset_outputs", all_outs(), 32'h0);
        tick(); tick();
        RST = 1'b1;
        tick();
        put(8'h3C);
        check("post_reset_err", {CMD_ERR, RF_WrEn}, {1'b1, 1'b0});
        tick(); tick();
        check("post_reset_no_wr", wr_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller between the UART receive/transmit datapath and the system register file and ALU.
- Parses byte frames from the UART receiver, sequences register-file writes and reads and ALU operations, and pushes responses toward the UART transmitter through the TX FIFO.
- Single clock domain (system clock). Clock-domain crossing to the UART clocks happens outside this block.

Parameters:
DATA_WIDTH, 8, byte width of UART, register-file and ALU operand data
ADDR_WIDTH, 4, register-file address width; the low ADDR_WIDTH bits of the address byte are used
FUN_WIDTH, 4, ALU function code width; the low FUN_WIDTH bits of the function byte are used

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte, synchronised into CLK
RX_D_VLD  in  1  one-cycle pulse per received byte
RF_Address  out  ADDR_WIDTH  register-file address
RF_WrEn  out  1  register-file write strobe
RF_RdEn  out  1  register-file read strobe
RF_WrData  out  DATA_WIDTH  register-file write data
RF_RdData  in  DATA_WIDTH  register-file read data
RF_RdData_VLD  in  1  read-data valid pulse
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  FUN_WIDTH  ALU function code
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
CLK_GATE_EN  out  1  enables the ALU clock gate
TX_P_DATA  out  DATA_WIDTH  byte pushed to the TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
FIFO_FULL  in  1  TX FIFO full; no push is allowed while high
CMD_ERR  out  1  one-cycle pulse on an unknown command or a dropped byte

Behaviour:
- Reset (RST low, asynchronous): state=IDLE. All outputs 0. Internal data and address registers cleared.
- All outputs are registered. A byte arriving with RX_D_VLD in cycle N takes effect on the outputs in cycle N+1.
- Frames:
  - 0xAA: write. Sequence ADDR, DATA. After DATA: RF_WrEn=1 for exactly one cycle with the latched RF_Address and RF_WrData. Return to IDLE. No response.
  - 0xBB: read. Sequence ADDR. After ADDR: RF_RdEn=1 for one cycle. Enter RD_WAIT. On RF_RdData_VLD, latch RF_RdData and enter TX_LO. Push one byte.
  - 0xCC: ALU with operands. Sequence A, B, FUN. Each operand causes a one-cycle RF_WrEn: A to address 0, B to address 1. After FUN: ALU_EN=1 for one cycle with ALU_FUN, then ALU_WAIT.
  - 0xDD: ALU without operands. Sequence FUN only, then the same ALU_EN/ALU_WAIT flow as 0xCC.
  - On ALU_OUT_VLD: latch ALU_OUT. Push the low byte (TX_LO), then the high byte (TX_HI).
  - Any other byte in IDLE: CMD_ERR pulse, remain in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- TX push rule:
  - In TX_LO/TX_HI, TX_D_VLD=1 for exactly one cycle, only in a cycle where FIFO_FULL=0. Otherwise hold and wait.
  - TX_P_DATA is valid in the same cycle as TX_D_VLD.
  - Read response: TX_LO then IDLE. ALU response: TX_LO, TX_HI, then IDLE.
- CLK_GATE_EN: high from entry to ALU_FUN (or from the 0xDD FUN state) until ALU_OUT_VLD is received. Low otherwise.
- ALU_EN and RF_WrEn are never high in the same cycle. The operand-B write completes before the ALU_EN cycle.
- Bytes arriving in RD_WAIT, ALU_WAIT, TX_LO or TX_HI are dropped, and CMD_ERR pulses. State is unaffected.
- RF_RdData_VLD or ALU_OUT_VLD outside its wait state is ignored.
- Reset asserted mid-frame aborts immediately to IDLE. No partial strobes are issued after release.
- Back-to-back frames with zero idle cycles between bytes are supported. After the final strobe cycle, a new command byte is accepted in the same cycle the state returns to IDLE.

Test Plan:
- Write: RX bytes 0xAA,0x05,0x3C → exactly one cycle with RF_WrEn=1, RF_Address=5, RF_WrData=0x3C. No TX_D_VLD.
- Read: RX 0xBB,0x05, then RF_RdData=0x3C with RF_RdData_VLD 2 cycles after RF_RdEn → single TX_D_VLD with TX_P_DATA=0x3C.
- ALU: RX 0xCC,0x12,0x34,0x00 → RF writes (0,0x12),(1,0x34), then ALU_EN with ALU_FUN=0. Return ALU_OUT=0x0046 → TX pushes 0x46 then 0x00. CLK_GATE_EN high from the FUN byte until ALU_OUT_VLD.
- Backpressure: during the 0xDD ALU response, hold FIFO_FULL=1 for 5 cycles → no TX_D_VLD while full. Both bytes are delivered in order after release; none is duplicated.
- Errors: RX 0x77 in IDLE → CMD_ERR pulse, state IDLE. A byte injected in RD_WAIT → CMD_ERR, and the read completes normally.
- Reset: assert RST after 0xAA,0x05 → all outputs 0 immediately. After release, RX 0x3C produces CMD_ERR and no RF_WrEn.
